// File: rtl/freeahb_arb_pkg.sv
// Shared types and constants for the FreeAHB two-requester arbiter.
// Holds the sequencer state encoding, HSIZE codes and the fixed single-beat controls.
package freeahb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic [31:0] M_MIN_LEN = 32'd0;
  localparam logic        M_CONT    = 1'b0;
  localparam logic        M_LOCK    = 1'b0;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [3:0]  prot;
  } req_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way picker: a lone request wins outright; on a tie either
// requester 0 wins (fixed priority) or the one that was not granted last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed_prio,
  output logic       grant
);

  // Grant index selection
  always_comb begin
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = fixed_prio ? 1'b0 : ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/freeahb_req_arbiter.sv
// Arbitrates two single-beat requesters onto the FreeAHB native request port,
// sequences the handshake and returns read data or a timeout error to the owner.
module freeahb_req_arbiter
  import freeahb_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 1024
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        rq0_valid,
  input  logic        rq0_write,
  input  logic [31:0] rq0_addr,
  input  logic [31:0] rq0_wdata,
  input  logic [2:0]  rq0_size,
  input  logic [3:0]  rq0_prot,
  output logic        rq0_ack,
  output logic [31:0] rq0_rdata,
  output logic        rq0_err,
  input  logic        rq1_valid,
  input  logic        rq1_write,
  input  logic [31:0] rq1_addr,
  input  logic [31:0] rq1_wdata,
  input  logic [2:0]  rq1_size,
  input  logic [3:0]  rq1_prot,
  output logic        rq1_ack,
  output logic [31:0] rq1_rdata,
  output logic        rq1_err,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_valid,
  output logic        m_write,
  output logic        m_read,
  output logic [2:0]  m_size,
  output logic [3:0]  m_prot,
  output logic [31:0] m_min_len,
  output logic        m_cont,
  output logic        m_lock,
  input  logic        m_next,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output logic        owner
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic             owner_q, owner_d;
  req_t             req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             m_valid_q, m_valid_d;
  logic             m_write_q, m_write_d;
  logic             m_read_q, m_read_d;
  logic             busy_q, busy_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic             err0_q, err0_d, err1_q, err1_d;
  logic [31:0]      rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic             sel_s;
  logic             expire_s;
  logic             done_err_s;
  logic [31:0]      done_rdata_s;
  req_t             rq0_req_s, rq1_req_s;

  assign rq0_req_s = '{write: rq0_write, addr: rq0_addr, wdata: rq0_wdata,
                       size: rq0_size, prot: rq0_prot};
  assign rq1_req_s = '{write: rq1_write, addr: rq1_addr, wdata: rq1_wdata,
                       size: rq1_size, prot: rq1_prot};

  rr_pick2 u_pick (
    .req        ({rq1_valid, rq0_valid}),
    .last       (owner_q),
    .fixed_prio (FIXED_PRIO != 0),
    .grant      (sel_s)
  );

  assign expire_s = (cnt_q == CNT_LAST);

  // Sequencer next state; a completing event takes precedence over expiry
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    req_d        = req_q;
    cnt_d        = '0;
    done_err_s   = 1'b0;
    done_rdata_s = 32'd0;
    case (state_q)
      IDLE: begin
        if (rq0_valid || rq1_valid) begin
          owner_d = sel_s;
          req_d   = sel_s ? rq1_req_s : rq0_req_s;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        if (m_next) begin
          state_d = req_q.write ? DONE : WAIT_RD;
        end else if (expire_s) begin
          state_d    = DONE;
          done_err_s = 1'b1;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT_RD: begin
        cnt_d = cnt_q + 1'b1;
        if (m_ready) begin
          state_d      = DONE;
          done_rdata_s = m_rdata;
        end else if (expire_s) begin
          state_d    = DONE;
          done_err_s = 1'b1;
        end else begin
          state_d = WAIT_RD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered output values derived from the upcoming state
  always_comb begin
    m_valid_d = (state_d == ISSUE);
    m_write_d = (state_d == ISSUE) && req_d.write;
    m_read_d  = (state_d == ISSUE) && !req_d.write;
    busy_d    = (state_d != IDLE);
    ack0_d    = (state_d == DONE) && !owner_d;
    ack1_d    = (state_d == DONE) && owner_d;
    err0_d    = ack0_d && done_err_s;
    err1_d    = ack1_d && done_err_s;
    rdata0_d  = ack0_d ? done_rdata_s : 32'd0;
    rdata1_d  = ack1_d ? done_rdata_s : 32'd0;
  end

  // State and output registers; owner resets to 1 so requester 0 wins first
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      owner_q   <= 1'b1;
      req_q     <= '0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_write_q <= 1'b0;
      m_read_q  <= 1'b0;
      busy_q    <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= 32'd0;
      rdata1_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_write_q <= m_write_d;
      m_read_q  <= m_read_d;
      busy_q    <= busy_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign m_addr    = req_q.addr;
  assign m_wdata   = req_q.wdata;
  assign m_size    = req_q.size;
  assign m_prot    = req_q.prot;
  assign m_valid   = m_valid_q;
  assign m_write   = m_write_q;
  assign m_read    = m_read_q;
  assign m_min_len = M_MIN_LEN;
  assign m_cont    = M_CONT;
  assign m_lock    = M_LOCK;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign rq0_ack   = ack0_q;
  assign rq1_ack   = ack1_q;
  assign rq0_err   = err0_q;
  assign rq1_err   = err1_q;
  assign rq0_rdata = rdata0_q;
  assign rq1_rdata = rdata1_q;

endmodule

// File: tb/tb_freeahb_req_arbiter.sv
// Directed bench for freeahb_req_arbiter: a round-robin instance (dut) and a
// fixed-priority instance (dut_fp, held in reset except for the arbitration test).
module tb_freeahb_req_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, rst_fp_n;
  logic        rq0_valid, rq0_write, rq1_valid, rq1_write;
  logic [31:0] rq0_addr, rq0_wdata, rq1_addr, rq1_wdata;
  logic [2:0]  rq0_size, rq1_size;
  logic [3:0]  rq0_prot, rq1_prot;
  logic        m_next, m_ready;
  logic [31:0] m_rdata;

  logic        a_rq0_ack, a_rq0_err, a_rq1_ack, a_rq1_err;
  logic [31:0] a_rq0_rdata, a_rq1_rdata, a_m_addr, a_m_wdata, a_m_min_len;
  logic        a_m_valid, a_m_write, a_m_read, a_m_cont, a_m_lock, a_busy, a_owner;
  logic [2:0]  a_m_size;
  logic [3:0]  a_m_prot;

  logic        b_rq0_ack, b_rq0_err, b_rq1_ack, b_rq1_err;
  logic [31:0] b_rq0_rdata, b_rq1_rdata, b_m_addr, b_m_wdata, b_m_min_len;
  logic        b_m_valid, b_m_write, b_m_read, b_m_cont, b_m_lock, b_busy, b_owner;
  logic [2:0]  b_m_size;
  logic [3:0]  b_m_prot;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  freeahb_req_arbiter #(.FIXED_PRIO(0), .TIMEOUT(16)) dut (
    .HCLK(clk), .HRESETn(rst_n),
    .rq0_valid(rq0_valid), .rq0_write(rq0_write), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq0_size(rq0_size), .rq0_prot(rq0_prot), .rq0_ack(a_rq0_ack), .rq0_rdata(a_rq0_rdata),
    .rq0_err(a_rq0_err),
    .rq1_valid(rq1_valid), .rq1_write(rq1_write), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rq1_size(rq1_size), .rq1_prot(rq1_prot), .rq1_ack(a_rq1_ack), .rq1_rdata(a_rq1_rdata),
    .rq1_err(a_rq1_err),
    .m_addr(a_m_addr), .m_wdata(a_m_wdata), .m_valid(a_m_valid), .m_write(a_m_write),
    .m_read(a_m_read), .m_size(a_m_size), .m_prot(a_m_prot), .m_min_len(a_m_min_len),
    .m_cont(a_m_cont), .m_lock(a_m_lock), .m_next(m_next), .m_ready(m_ready),
    .m_rdata(m_rdata), .busy(a_busy), .owner(a_owner)
  );

  freeahb_req_arbiter #(.FIXED_PRIO(1), .TIMEOUT(16)) dut_fp (
    .HCLK(clk), .HRESETn(rst_fp_n),
    .rq0_valid(rq0_valid), .rq0_write(rq0_write), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq0_size(rq0_size), .rq0_prot(rq0_prot), .rq0_ack(b_rq0_ack), .rq0_rdata(b_rq0_rdata),
    .rq0_err(b_rq0_err),
    .rq1_valid(rq1_valid), .rq1_write(rq1_write), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rq1_size(rq1_size), .rq1_prot(rq1_prot), .rq1_ack(b_rq1_ack), .rq1_rdata(b_rq1_rdata),
    .rq1_err(b_rq1_err),
    .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_valid(b_m_valid), .m_write(b_m_write),
    .m_read(b_m_read), .m_size(b_m_size), .m_prot(b_m_prot), .m_min_len(b_m_min_len),
    .m_cont(b_m_cont), .m_lock(b_m_lock), .m_next(m_next), .m_ready(m_ready),
    .m_rdata(m_rdata), .busy(b_busy), .owner(b_owner)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 1'b0; rst_fp_n = 1'b0;
    rq0_valid = 1'b0; rq0_write = 1'b0; rq0_addr = 32'd0; rq0_wdata = 32'd0;
    rq0_size = 3'd0; rq0_prot = 4'd0;
    rq1_valid = 1'b0; rq1_write = 1'b0; rq1_addr = 32'd0; rq1_wdata = 32'd0;
    rq1_size = 3'd0; rq1_prot = 4'd0;
    m_next = 1'b0; m_ready = 1'b0; m_rdata = 32'd0;

    // Reset values
    step_n(2);
    chk_eq("rst_m_valid", {31'd0, a_m_valid}, 32'd0);
    chk_eq("rst_busy", {31'd0, a_busy}, 32'd0);
    chk_eq("rst_owner", {31'd0, a_owner}, 32'd1);
    chk_eq("rst_acks", {30'd0, a_rq1_ack, a_rq0_ack}, 32'd0);
    chk_eq("rst_m_addr", a_m_addr, 32'd0);
    chk_eq("rst_rw", {30'd0, a_m_write, a_m_read}, 32'd0);
    chk_eq("rst_min_len", a_m_min_len, 32'd0);
    rst_n = 1'b1;
    step();

    // Single write from rq0
    rq0_valid = 1'b1; rq0_write = 1'b1; rq0_addr = 32'h4000_0100; rq0_wdata = 32'hDEAD_BEEF;
    rq0_size = 3'b010; rq0_prot = 4'h3;
    step();
    chk_eq("wr_m_valid_c1", {31'd0, a_m_valid}, 32'd1);
    chk_eq("wr_m_addr", a_m_addr, 32'h4000_0100);
    chk_eq("wr_m_wdata", a_m_wdata, 32'hDEAD_BEEF);
    chk_eq("wr_m_write_read", {30'd0, a_m_write, a_m_read}, 32'd2);
    chk_eq("wr_size_prot", {25'd0, a_m_size, a_m_prot}, {25'd0, 3'b010, 4'h3});
    chk_eq("wr_owner", {31'd0, a_owner}, 32'd0);
    chk_eq("wr_ack_c1", {31'd0, a_rq0_ack}, 32'd0);
    m_next = 1'b1;
    step();
    m_next = 1'b0;
    chk_eq("wr_ack_c2", {31'd0, a_rq0_ack}, 32'd1);
    chk_eq("wr_err", {31'd0, a_rq0_err}, 32'd0);
    chk_eq("wr_rdata", a_rq0_rdata, 32'd0);
    chk_eq("wr_m_valid_c2", {31'd0, a_m_valid}, 32'd0);
    rq0_valid = 1'b0;
    step();
    chk_eq("wr_ack_c3", {31'd0, a_rq0_ack}, 32'd0);
    chk_eq("wr_busy_c3", {31'd0, a_busy}, 32'd0);

    // Read from rq1, data 4 cycles after m_next; stray m_ready in ISSUE ignored
    rq1_valid = 1'b1; rq1_write = 1'b0; rq1_addr = 32'h8000_0040; rq1_wdata = 32'd0;
    rq1_size = 3'b010; rq1_prot = 4'h1;
    step();
    chk_eq("rd_m_read", {30'd0, a_m_write, a_m_read}, 32'd1);
    chk_eq("rd_owner", {31'd0, a_owner}, 32'd1);
    chk_eq("rd_m_addr", a_m_addr, 32'h8000_0040);
    m_next = 1'b1; m_ready = 1'b1; m_rdata = 32'hBAD0_BAD0;
    step();
    m_next = 1'b0; m_ready = 1'b0;
    chk_eq("rd_m_valid_c2", {31'd0, a_m_valid}, 32'd0);
    chk_eq("rd_ack_c2", {31'd0, a_rq1_ack}, 32'd0);
    step_n(3);
    m_ready = 1'b1; m_rdata = 32'h1234_5678;
    chk_eq("rd_ack_c5", {31'd0, a_rq1_ack}, 32'd0);
    step();
    m_ready = 1'b0; m_rdata = 32'hFFFF_FFFF;
    chk_eq("rd_ack_c6", {31'd0, a_rq1_ack}, 32'd1);
    chk_eq("rd_rdata", a_rq1_rdata, 32'h1234_5678);
    chk_eq("rd_err", {31'd0, a_rq1_err}, 32'd0);
    chk_eq("rd_rq0_quiet", {31'd0, a_rq0_ack}, 32'd0);
    chk_eq("rd_rq0_rdata", a_rq0_rdata, 32'd0);
    rq1_valid = 1'b0;
    step();
    chk_eq("rd_rdata_after", a_rq1_rdata, 32'd0);

    // Timeout: rq0 read, m_next never asserted
    rq0_valid = 1'b1; rq0_write = 1'b0; rq0_addr = 32'h0000_2000; m_rdata = 32'hA5A5_A5A5;
    step();
    chk_eq("to_m_read", {30'd0, a_m_write, a_m_read}, 32'd1);
    step_n(15);
    chk_eq("to_m_valid_c16", {31'd0, a_m_valid}, 32'd1);
    chk_eq("to_ack_c16", {31'd0, a_rq0_ack}, 32'd0);
    step();
    chk_eq("to_ack_c17", {31'd0, a_rq0_ack}, 32'd1);
    chk_eq("to_err", {31'd0, a_rq0_err}, 32'd1);
    chk_eq("to_rdata", a_rq0_rdata, 32'd0);
    chk_eq("to_m_valid_c17", {31'd0, a_m_valid}, 32'd0);
    rq0_valid = 1'b0;
    step();
    chk_eq("to_m_valid_c18", {31'd0, a_m_valid}, 32'd0);
    chk_eq("to_err_c18", {31'd0, a_rq0_err}, 32'd0);

    // m_next in the expiry cycle completes normally
    rq1_valid = 1'b1; rq1_write = 1'b1; rq1_addr = 32'h0000_3000; rq1_wdata = 32'h0BAD_F00D;
    step();
    step_n(15);
    chk_eq("ex_m_valid_c16", {31'd0, a_m_valid}, 32'd1);
    m_next = 1'b1;
    step();
    m_next = 1'b0;
    chk_eq("ex_ack", {31'd0, a_rq1_ack}, 32'd1);
    chk_eq("ex_err", {31'd0, a_rq1_err}, 32'd0);
    chk_eq("ex_rq0_quiet", {31'd0, a_rq0_ack}, 32'd0);
    rq1_valid = 1'b0;
    step();

    // Reset pulsed while in WAIT_RD
    rq1_valid = 1'b1; rq1_write = 1'b0; rq1_addr = 32'h0000_4000;
    step();
    m_next = 1'b1;
    step();
    m_next = 1'b0;
    step();
    chk_eq("mr_busy_pre", {31'd0, a_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("mr_busy", {31'd0, a_busy}, 32'd0);
    chk_eq("mr_owner", {31'd0, a_owner}, 32'd1);
    chk_eq("mr_m_addr", a_m_addr, 32'd0);
    chk_eq("mr_acks", {30'd0, a_rq1_ack, a_rq0_ack}, 32'd0);
    rq1_valid = 1'b0;
    step();
    #2 rst_n = 1'b1;
    m_ready = 1'b1; m_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_eq("mr_no_ack", {30'd0, a_rq1_ack, a_rq0_ack}, 32'd0);
    end
    m_ready = 1'b0;
    rq0_valid = 1'b1; rq0_write = 1'b1; rq0_addr = 32'h0000_0100;
    rq1_valid = 1'b1; rq1_write = 1'b1; rq1_addr = 32'h0000_0200;
    step();
    chk_eq("mr_grant_owner", {31'd0, a_owner}, 32'd0);
    chk_eq("mr_grant_addr", a_m_addr, 32'h0000_0100);
    m_next = 1'b1;
    step();
    m_next = 1'b0;
    chk_eq("mr_grant_ack", {30'd0, a_rq1_ack, a_rq0_ack}, 32'd1);
    rq0_valid = 1'b0; rq1_valid = 1'b0;
    step();

    // Both held valid: round-robin alternates, fixed priority always picks rq0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; rst_fp_n = 1'b1;
    step();
    rq0_valid = 1'b1; rq1_valid = 1'b1; m_next = 1'b1;
    for (int t = 0; t < 8; t++) begin
      step();
      chk_eq("arb_rr_owner", {31'd0, a_owner}, 32'(t % 2));
      chk_eq("arb_rr_addr", a_m_addr, (t % 2 == 1) ? 32'h0000_0200 : 32'h0000_0100);
      chk_eq("arb_fp_owner", {31'd0, b_owner}, 32'd0);
      step();
      chk_eq("arb_rr_acks", {30'd0, a_rq1_ack, a_rq0_ack}, (t % 2 == 1) ? 32'd2 : 32'd1);
      chk_eq("arb_fp_acks", {30'd0, b_rq1_ack, b_rq0_ack}, 32'd1);
      step();
    end
    rq0_valid = 1'b0; rq1_valid = 1'b0; m_next = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
